// File: rtl/dec_check_if.sv
// Bus between the decrypt-result checker and its controller / dec_memory:
// start pulse, RAM read path and the pass/fail result outputs.
interface dec_check_if;
    logic       start;
    logic [7:0] data_from_dec_mem;
    logic [7:0] addr_to_dec_mem;
    logic       task_on;
    logic       fin_strobe;
    logic       result_ready;
    logic       msg_ok;
    logic [7:0] bad_index;

    modport slave (
        input  start,
        input  data_from_dec_mem,
        output addr_to_dec_mem,
        output task_on,
        output fin_strobe,
        output result_ready,
        output msg_ok,
        output bad_index
    );

    modport master (
        output start,
        output data_from_dec_mem,
        input  addr_to_dec_mem,
        input  task_on,
        input  fin_strobe,
        input  result_ready,
        input  msg_ok,
        input  bad_index
    );
endinterface

// File: rtl/dec_check.sv
// Reads the decrypted message back from dec_memory and judges it plausible
// when every byte is lowercase ASCII or space; reports the first bad index.
module dec_check #(
    parameter int MSG_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    dec_check_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Termination index; MSG_LEN=256 ends at 255 so idx never wraps.
    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    state_t     state_r, state_s;
    logic [7:0] idx_r, idx_s;
    logic [7:0] addr_r, addr_s;
    logic [7:0] bad_r, bad_s;
    logic       task_on_r, task_on_s;
    logic       fin_r, fin_s;
    logic       ready_r, ready_s;
    logic       ok_r, ok_s;

    function automatic logic is_legal(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Next-state and next-output computation; results hold unless updated.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        addr_s  = addr_r;
        bad_s   = bad_r;
        ok_s    = ok_r;
        ready_s = ready_r;
        fin_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = READ;
                    idx_s   = 8'd0;
                    addr_s  = 8'd0;
                    ready_s = 1'b0;
                    ok_s    = 1'b0;
                    bad_s   = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            READ:  state_s = WAIT;
            WAIT:  state_s = CHECK;
            CHECK: begin
                if (!is_legal(bus.data_from_dec_mem)) begin
                    state_s = DONE;
                    ok_s    = 1'b0;
                    bad_s   = idx_r;
                    ready_s = 1'b1;
                    fin_s   = 1'b1;
                end else if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                    ok_s    = 1'b1;
                    bad_s   = 8'd0;
                    ready_s = 1'b1;
                    fin_s   = 1'b1;
                end else begin
                    state_s = READ;
                    idx_s   = idx_r + 8'd1;
                    addr_s  = idx_r + 8'd1;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        task_on_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 8'd0;
            addr_r    <= 8'd0;
            bad_r     <= 8'd0;
            task_on_r <= 1'b0;
            fin_r     <= 1'b0;
            ready_r   <= 1'b0;
            ok_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            addr_r    <= addr_s;
            bad_r     <= bad_s;
            task_on_r <= task_on_s;
            fin_r     <= fin_s;
            ready_r   <= ready_s;
            ok_r      <= ok_s;
        end
    end

    assign bus.addr_to_dec_mem = addr_r;
    assign bus.task_on         = task_on_r;
    assign bus.fin_strobe      = fin_r;
    assign bus.result_ready    = ready_r;
    assign bus.msg_ok          = ok_r;
    assign bus.bad_index       = bad_r;

endmodule
